// File: rtl/axi4_slave_pkg.sv
// Shared AXI4 slave definitions: response encoding and the FORCE_OKAY mapping helper.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  function automatic resp_t map_resp(input bit force_okay, input logic [1:0] resp);
    return force_okay ? OKAY : resp_t'(resp);
  endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push-while-full-and-popping, occupancy count
// and a sticky overflow flag. Read data is masked to zero when empty.
module axi4_sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid_i,
  input  logic [WIDTH-1:0]     push_data_i,
  output logic                 push_ready_o,
  output logic                 pop_valid_o,
  input  logic                 pop_ready_i,
  output logic [WIDTH-1:0]     pop_data_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 do_push, do_pop;

  assign pop_valid_o  = (count_q != '0);
  assign do_pop       = pop_valid_o && pop_ready_i;
  assign push_ready_o = (count_q < CNT_WIDTH'(DEPTH)) || do_pop;
  assign do_push      = push_valid_i && push_ready_o;
  // Masking keeps the head output at zero after reset although storage is not reset.
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_valid_i && !push_ready_o) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi4_slave_bresp_queue.sv
// AXI4 slave write-response queue: one {BID, BRESP} entry per completed burst, drained
// over the B channel in push order.
module axi4_slave_bresp_queue
  import axi4_slave_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4,
  parameter bit          FORCE_OKAY = 1'b0,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [ID_WIDTH-1:0]  push_id,
  input  logic [1:0]           push_resp,
  output logic                 push_ready,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [ID_WIDTH-1:0]  bid,
  output logic [1:0]           bresp,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    resp_t               resp;
  } bresp_entry_t;

  bresp_entry_t push_entry, head_entry;

  assign push_entry.id   = push_id;
  assign push_entry.resp = map_resp(FORCE_OKAY, push_resp);

  axi4_sync_fifo #(
    .WIDTH     ($bits(bresp_entry_t)),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (push_valid),
    .push_data_i  (push_entry),
    .push_ready_o (push_ready),
    .pop_valid_o  (bvalid),
    .pop_ready_i  (bready),
    .pop_data_o   (head_entry),
    .count_o      (count),
    .overflow_o   (overflow)
  );

  assign bid   = head_entry.id;
  assign bresp = head_entry.resp;

endmodule

// File: tb/tb_axi4_slave_bresp_queue.sv
// Scoreboard bench for axi4_slave_bresp_queue; a FORCE_OKAY=1 twin shares the stimulus.
module tb_axi4_slave_bresp_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_valid = 1'b0;
  logic [3:0] push_id = '0;
  logic [1:0] push_resp = '0;
  logic       bready = 1'b0;

  logic       push_ready, bvalid, overflow;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic [2:0] count;
  logic       push_ready_fo, bvalid_fo, overflow_fo;
  logic [3:0] bid_fo;
  logic [1:0] bresp_fo;
  logic [2:0] count_fo;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_fo_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi4_slave_bresp_queue #(.ID_WIDTH(4), .DEPTH(4), .FORCE_OKAY(1'b0)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_id(push_id),
    .push_resp(push_resp), .push_ready(push_ready), .bvalid(bvalid), .bready(bready),
    .bid(bid), .bresp(bresp), .count(count), .overflow(overflow)
  );

  axi4_slave_bresp_queue #(.ID_WIDTH(4), .DEPTH(4), .FORCE_OKAY(1'b1)) dut_fo (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_id(push_id),
    .push_resp(push_resp), .push_ready(push_ready_fo), .bvalid(bvalid_fo), .bready(bready),
    .bid(bid_fo), .bresp(bresp_fo), .count(count_fo), .overflow(overflow_fo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic expect_b(input logic [3:0] id, input logic [1:0] resp);
    exp_q.push_back('{id, resp});
    exp_fo_q.push_back('{id, 2'b00});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [3:0] id, input logic [1:0] resp);
    push_valid = 1'b1;
    push_id    = id;
    push_resp  = resp;
  endtask

  // Monitor: every B handshake is checked against the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bvalid && bready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected: got bid=%0h bresp=%0h, required no response", bid, bresp);
      end else begin
        e = exp_q.pop_front();
        chk("b_id", 32'(bid), 32'(e.id));
        chk("b_resp", 32'(bresp), 32'(e.resp));
      end
    end
    if (!rst && bvalid_fo && bready) begin
      if (exp_fo_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL bfo_unexpected: got bid=%0h bresp=%0h, required no response",
                 bid_fo, bresp_fo);
      end else begin
        e = exp_fo_q.pop_front();
        chk("bfo_id", 32'(bid_fo), 32'(e.id));
        chk("bfo_resp", 32'(bresp_fo), 32'(e.resp));
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_bid", 32'(bid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single push, immediate retire
    drive_push(4'h3, 2'b00); bready = 1'b1; expect_b(4'h3, 2'b00);
    step();
    push_valid = 1'b0;
    chk("single_bvalid", 32'(bvalid), 1);
    chk("single_count", 32'(count), 1);
    chk("single_bid", 32'(bid), 3);
    step();
    chk("single_bvalid_after", 32'(bvalid), 0);
    chk("single_count_after", 32'(count), 0);

    // Fill with stall, then overflow
    bready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(4'(i), 2'(i % 4)); expect_b(4'(i), 2'(i % 4));
      step();
      chk("stall_bid", 32'(bid), 1);
      chk("stall_bresp", 32'(bresp), 1);
    end
    chk("full_count", 32'(count), 4);
    chk("full_push_ready", 32'(push_ready), 0);
    drive_push(4'h5, 2'b00);
    step();
    push_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_bid", 32'(bid), 1);
    step();
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset to clear, refill, then push during pop while full
    rst = 1'b1;
    exp_q.delete(); exp_fo_q.delete();
    step();
    rst = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) begin
      drive_push(4'(i), 2'b00); expect_b(4'(i), 2'b00);
      step();
    end
    drive_push(4'h9, 2'b00); bready = 1'b1; expect_b(4'h9, 2'b00);
    #1;
    chk("full_pop_push_ready", 32'(push_ready), 1);
    step();
    push_valid = 1'b0;
    chk("full_pop_count", 32'(count), 4);
    chk("full_pop_overflow", 32'(overflow), 0);
    chk("full_pop_head", 32'(bid), 2);
    repeat (4) step();
    chk("drain_count", 32'(count), 0);
    chk("drain_bvalid", 32'(bvalid), 0);

    // SLVERR passthrough vs FORCE_OKAY
    bready = 1'b0;
    drive_push(4'h6, 2'b10); expect_b(4'h6, 2'b10);
    step();
    push_valid = 1'b0;
    chk("slverr_bresp", 32'(bresp), 2);
    chk("force_okay_bresp", 32'(bresp_fo), 0);
    bready = 1'b1;
    step();
    chk("slverr_drained", 32'(count), 0);

    // Streaming: one push and one retire per cycle across pointer wrap
    for (int i = 0; i < 16; i++) begin
      drive_push(4'(i), 2'(i % 4)); expect_b(4'(i), 2'(i % 4));
      step();
      chk("stream_bvalid", 32'(bvalid), 1);
      chk("stream_count", 32'(count), 1);
    end
    push_valid = 1'b0;
    step();
    chk("stream_end_count", 32'(count), 0);

    // Asynchronous reset with entries queued
    bready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      drive_push(4'(i), 2'b00); expect_b(4'(i), 2'b00);
      step();
    end
    push_valid = 1'b0;
    chk("pre_rst_bvalid", 32'(bvalid), 1);
    chk("pre_rst_count", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_bvalid", 32'(bvalid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_push_ready", 32'(push_ready), 1);
    chk("arst_bid", 32'(bid), 0);
    exp_q.delete(); exp_fo_q.delete();
    step();
    rst = 1'b0;
    drive_push(4'hA, 2'b01); bready = 1'b1; expect_b(4'hA, 2'b01);
    step();
    push_valid = 1'b0;
    chk("post_rst_bvalid", 32'(bvalid), 1);
    chk("post_rst_bid", 32'(bid), 10);
    step();
    chk("post_rst_count", 32'(count), 0);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    chk("sb_fo_leftover", 32'(exp_fo_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_slave_bresp_queue.md
Name: axi4_slave_bresp_queue

Overview:
Parametrised write-response channel for the AXI4 slave. It queues one response per completed write burst (ID plus response code) in a FIFO of configurable depth, so several bursts can be outstanding. It drives the B channel with a full AXI-compliant valid/ready handshake. It sits between the slave write-data stage, which pushes on the accepted WLAST beat, and the master's B channel. It back-pressures the write-data stage when the queue is full.

Parameters:
ID_WIDTH, 4, width of AWID/BID.
DEPTH, 4, number of outstanding responses held; power of two, minimum 2.
FORCE_OKAY, 0, 1 = ignore push_resp and always return OKAY; 0 = return push_resp.
CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
clk  input  1  clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
push_valid  input  1  write-data stage completed a burst (WLAST beat accepted) this cycle.
push_id  input  ID_WIDTH  AWID captured for that burst.
push_resp  input  2  response code for that burst (resp_t encoding).
push_ready  output  1  queue can accept a push; write-data stage must not accept WLAST while low.
bvalid  output  1  B channel valid.
bready  input  1  B channel ready from master.
bid  output  ID_WIDTH  B channel ID.
bresp  output  2  B channel response.
count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
overflow  output  1  sticky error flag: a push was attempted while the queue was full and no pop occurred.

Behaviour:
- Reset (rst high, asynchronous): count=0, rd/wr pointers=0, bvalid=0, bid=0, bresp=OKAY, overflow=0, push_ready=1. Storage contents need not be reset.
- Reset mid-operation: all queued responses are discarded. Outputs take reset values immediately, without waiting for a clock edge.
- Push: on a clock edge with push_valid && push_ready, store {push_id, resp} at wr_ptr and advance wr_ptr. resp = OKAY if FORCE_OKAY=1, else push_resp.
- Pop: on a clock edge with bvalid && bready, advance rd_ptr.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- count updates per edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- bvalid = (count != 0). bid and bresp are read from the entry at rd_ptr. All three are derived only from registers, with no combinational path from any input.
- Latency: a push at edge N into an empty queue gives bvalid=1 in the cycle after edge N, carrying that entry.
- AXI stability: while bvalid && !bready, bid and bresp hold constant. A simultaneous push never alters the head entry.
- Back-to-back: with bready held high, one response retires per cycle. In-order delivery: FIFO order equals push order, with no reordering by ID.
- push_ready = (count < DEPTH) || (bvalid && bready). When full, a push in the same cycle as a pop is accepted.
- Full and empty boundaries:
  - Empty with a simultaneous push: no pop can occur, because bvalid=0.
  - Full with a push and no pop: the push is dropped, the queue is unchanged, and overflow is set to 1. overflow stays set until reset.
- bready asserted while bvalid=0 has no effect.

Decomposition:
- Shared package axi4_slave_pkg:
  - typedef enum logic [1:0] resp_t, with OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - A packed struct bresp_entry_t {id, resp}, parametrised by ID_WIDTH via the module's local type.
- One natural sub-module: axi4_sync_fifo. It is a generic DEPTH x WIDTH synchronous FIFO with simultaneous push/pop when full, count, and an overflow flag. It is reusable by the AR/R path.
- The top level adds the FORCE_OKAY mapping and the B-channel port naming.

Test Plan:
- Reset, then a single push (id=4'h3, resp=OKAY) with bready=1 -> bvalid=1 in the next cycle with bid=3 and bresp=00. bvalid=0 one cycle after the handshake; count goes 0 -> 1 -> 0.
- Push ids 1, 2, 3, 4 (DEPTH=4) with bready=0 -> count=4 and push_ready=0. A fifth push sets overflow=1 with count still 4. bid stays 1 and bresp stays constant throughout the stall.
- Full queue, push id=9 and bready=1 in the same cycle -> push accepted, count stays 4, overflow stays 0. Responses drain in order 2, 3, 4, 9.
- Push resp=SLVERR with FORCE_OKAY=0 -> bresp=2'b10. The same stimulus with FORCE_OKAY=1 -> bresp=2'b00.
- Continuous pushes every cycle with bready=1 -> bvalid stays high and one response retires per cycle. Over 16 pushes, pointer wrap-around is exercised and the id sequence is preserved.
- Assert rst asynchronously with 3 entries queued and bvalid=1 -> bvalid, count and overflow go to 0 before the next clock edge. After rst deasserts, a new push appears after 1 cycle.
